// File: rtl/spike_frame_sequencer.sv
// Wishbone master that carries one spike frame through the dual-core network:
// writes 16 input words into IMEM, triggers calculation, reads 16 OMEM words
// back and streams them out. Every bus access is a single transfer, preceded
// by one idle cycle, and is aborted if the slave does not ack within ACK_TIMEOUT.
module spike_frame_sequencer #(
  parameter logic [31:0] IMEM_BASE_0    = 32'h80000000,
  parameter logic [31:0] IMEM_BASE_1    = 32'h80010000,
  parameter logic [31:0] OMEM_BASE_0    = 32'h80040000,
  parameter logic [31:0] OMEM_BASE_1    = 32'h80050000,
  parameter logic [31:0] CALC_ADDR      = 32'h80060000,
  parameter logic [31:0] CALC_DATA      = 32'h00000003,
  parameter int          WORDS_PER_CORE = 8,
  parameter int          ACK_TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [15:0] frame_cnt_o
);

  localparam int IDX_W = $clog2(2 * WORDS_PER_CORE);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WORDS_PER_CORE - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W:0]   drop_reg;     // input words still to discard after an abort
  logic [TMR_W-1:0] timer_reg;
  logic             stb_reg;
  logic [31:0]      wr_data_reg;
  logic [31:0]      rd_data_reg;
  logic             err_reg;
  logic [15:0]      frame_cnt_reg;

  logic        bus_state;
  logic        ack_seen;
  logic        timeout;
  logic        last_word;
  logic        accept_word;
  logic        out_take;
  logic [31:0] word_off;
  logic [31:0] addr;

  assign bus_state   = (state_reg == S_WR) || (state_reg == S_CALC) || (state_reg == S_RD);
  assign ack_seen    = stb_reg && wbm_ack_i;
  assign timeout     = stb_reg && !wbm_ack_i && (timer_reg == TMR_W'(ACK_TIMEOUT - 1));
  assign last_word   = (idx_reg == LAST_IDX);
  assign out_take    = (state_reg == S_OUT) && m_ready_i;
  // A word arriving in IDLE while a discard is pending is swallowed, not latched.
  assign accept_word = s_valid_i && ((state_reg == S_LOAD) ||
                                     ((state_reg == S_IDLE) && (drop_reg == '0)));
  assign word_off    = {{(32 - IDX_W - 1){1'b0}}, idx_reg[IDX_W-2:0], 2'b00};

  // Address of the transfer belonging to the current state and index.
  always_comb begin
    addr = 32'h0;
    case (state_reg)
      S_WR:    addr = (idx_reg[IDX_W-1] ? IMEM_BASE_1 : IMEM_BASE_0) + word_off;
      S_CALC:  addr = CALC_ADDR;
      S_RD:    addr = (idx_reg[IDX_W-1] ? OMEM_BASE_1 : OMEM_BASE_0) + word_off;
      default: addr = 32'h0;
    endcase
  end

  // Bus fields are zero outside a transfer; state/idx are frozen while stb is high.
  assign wbm_cyc_o = stb_reg;
  assign wbm_stb_o = stb_reg;
  assign wbm_we_o  = stb_reg && (state_reg != S_RD);
  assign wbm_sel_o = stb_reg ? 4'hF : 4'h0;
  assign wbm_adr_o = stb_reg ? addr : 32'h0;
  assign wbm_dat_o = (stb_reg && state_reg == S_CALC) ? CALC_DATA :
                     (stb_reg && state_reg == S_WR)   ? wr_data_reg : 32'h0;

  assign s_ready_o    = wb_rst_ni && ((state_reg == S_IDLE) || (state_reg == S_LOAD));
  assign m_valid_o    = (state_reg == S_OUT);
  assign m_last_o     = m_valid_o && last_word;
  assign m_data_o     = rd_data_reg;
  assign busy_o       = (state_reg != S_IDLE);
  assign frame_done_o = out_take && last_word;
  assign err_o        = err_reg;
  assign frame_cnt_o  = frame_cnt_reg;

  // Frame sequencing: state, word index and post-abort discard count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      drop_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (s_valid_i) begin
            if (drop_reg != '0) begin
              drop_reg <= drop_reg - 1'b1;
            end else begin
              idx_reg   <= '0;
              state_reg <= S_WR;
            end
          end
        end
        S_WR: begin
          if (timeout) begin
            drop_reg  <= {1'b0, LAST_IDX - idx_reg};
            state_reg <= S_IDLE;
          end else if (ack_seen) begin
            if (last_word) begin
              state_reg <= S_CALC;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (s_valid_i) state_reg <= S_WR;
        end
        S_CALC: begin
          if (timeout) begin
            state_reg <= S_IDLE;
          end else if (ack_seen) begin
            idx_reg   <= '0;
            state_reg <= S_RD;
          end
        end
        S_RD: begin
          if (timeout)       state_reg <= S_IDLE;
          else if (ack_seen) state_reg <= S_OUT;
        end
        S_OUT: begin
          if (m_ready_i) begin
            if (last_word) begin
              state_reg <= S_IDLE;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= S_RD;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Strobe rises one cycle after entering a bus state, so every transfer is preceded by an idle cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stb_reg   <= 1'b0;
      timer_reg <= '0;
    end else begin
      if (stb_reg) begin
        if (wbm_ack_i || timeout) stb_reg <= 1'b0;
      end else if (bus_state) begin
        stb_reg <= 1'b1;
      end
      if (stb_reg && !wbm_ack_i && !timeout) timer_reg <= timer_reg + TMR_W'(1);
      else                                   timer_reg <= '0;
    end
  end

  // Data capture: input word into the write register, read data into the output register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_data_reg <= 32'h0;
      rd_data_reg <= 32'h0;
    end else begin
      if (accept_word)                      wr_data_reg <= s_data_i;
      if (state_reg == S_RD && ack_seen)    rd_data_reg <= wbm_dat_i;
    end
  end

  // Sticky error flag (a new timeout beats a clear) and completed-frame counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_reg       <= 1'b0;
      frame_cnt_reg <= 16'h0;
    end else begin
      if (timeout)        err_reg <= 1'b1;
      else if (err_clr_i) err_reg <= 1'b0;
      if (out_take && last_word) frame_cnt_reg <= frame_cnt_reg + 16'h1;
    end
  end

endmodule

// File: tb/tb_spike_frame_sequencer.sv
// Directed bench for spike_frame_sequencer with a behavioural Wishbone slave
// (configurable wait states, optional hang on one address) and a transfer log.
module tb_spike_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack = 1'b0;
  logic [31:0] dat_i = 32'h0;
  logic        busy, frame_done, err;
  logic        err_clr = 1'b0;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;

  // slave control and log
  int          wait_cfg = 0;
  logic        hang_en = 1'b0;
  int          stb_cycles = 0;
  int          last_stb_cycles = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [31:0] log_adr [64];
  logic [31:0] log_dat [64];
  logic        log_we  [64];
  int          log_n = 0;

  always #5 clk = ~clk;

  spike_frame_sequencer dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy_o(busy), .frame_done_o(frame_done), .err_o(err), .err_clr_i(err_clr),
    .frame_cnt_o(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // OMEM read data: core 0 words give A5000000+w, core 1 words give A5000008+w.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    logic [31:0] v;
    v = 32'hA5000000 | {29'h0, a[4:2]};
    if (a[31:16] == 16'h8005) v = v | 32'h8;
    return v;
  endfunction

  // Behavioural slave: acks after wait_cfg wait states, checks hold stability.
  initial begin
    forever begin
      @(negedge clk);
      if (stb && cyc && !ack) begin
        if (stb_cycles == 0) begin
          cap_adr = adr; cap_dat = dat_o; cap_we = we;
          chk("sel_active", {28'h0, sel}, 32'hF);
        end else begin
          chk("adr_hold", adr, cap_adr);
          chk("dat_hold", dat_o, cap_dat);
          chk("we_hold", {31'h0, we}, {31'h0, cap_we});
        end
        stb_cycles++;
        if (!(hang_en && we && adr == 32'h8000001C) && stb_cycles > wait_cfg) begin
          ack = 1'b1;
          dat_i = we ? 32'h0 : rd_val(adr);
          if (log_n < 64) begin
            log_adr[log_n] = adr;
            log_dat[log_n] = we ? dat_o : dat_i;
            log_we[log_n]  = we;
          end
          log_n++;
        end
      end else begin
        if (!stb) begin
          if (stb_cycles != 0) last_stb_cycles = stb_cycles;
          stb_cycles = 0;
        end
        ack = 1'b0;
        dat_i = 32'h0;
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    int t;
    for (t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk("s_ready_wait", {31'h0, s_ready}, 32'h1);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    $display("in  word=%h", d);
  endtask

  task automatic take_word(input int k, input int stall_at);
    logic [31:0] held;
    for (int t = 0; t < 2000 && !m_valid; t++) @(negedge clk);
    chk("m_valid", {31'h0, m_valid}, 32'h1);
    chk("m_data", m_data, 32'hA5000000 + k);
    chk("m_last", {31'h0, m_last}, (k == 15) ? 32'h1 : 32'h0);
    if (k == stall_at) begin
      held = m_data;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        chk("stall_valid", {31'h0, m_valid}, 32'h1);
        chk("stall_data", m_data, held);
        chk("stall_cyc", {31'h0, cyc}, 32'h0);
      end
    end
    m_ready = 1'b1;
    #1;
    chk("frame_done", {31'h0, frame_done}, (k == 15) ? 32'h1 : 32'h0);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    $display("out word=%0d data=%h last=%0d", k, m_data, m_last);
  endtask

  task automatic check_log(input logic [31:0] base);
    logic [31:0] ea;
    chk("log_count", log_n, 33);
    for (int i = 0; i < 33 && i < log_n; i++) begin
      if (i < 16) begin
        ea = ((i < 8) ? 32'h80000000 : 32'h80010000) + 4 * (i % 8);
        chk("wr_adr", log_adr[i], ea);
        chk("wr_dat", log_dat[i], base + i);
        chk("wr_we", {31'h0, log_we[i]}, 32'h1);
      end else if (i == 16) begin
        chk("calc_adr", log_adr[i], 32'h80060000);
        chk("calc_dat", log_dat[i], 32'h00000003);
        chk("calc_we", {31'h0, log_we[i]}, 32'h1);
      end else begin
        ea = (((i - 17) < 8) ? 32'h80040000 : 32'h80050000) + 4 * ((i - 17) % 8);
        chk("rd_adr", log_adr[i], ea);
        chk("rd_we", {31'h0, log_we[i]}, 32'h0);
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] base, input int stall_at, input logic [15:0] exp_cnt);
    log_n = 0;
    for (int i = 0; i < 16; i++) send_word(base + i);
    for (int k = 0; k < 16; k++) take_word(k, stall_at);
    @(negedge clk);
    check_log(base);
    chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, exp_cnt});
    chk("idle_busy", {31'h0, busy}, 32'h0);
    $display("frame base=%h cnt=%h", base, frame_cnt);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cyc", {31'h0, cyc}, 32'h0);
    chk("rst_ready", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_sready", {31'h0, s_ready}, 32'h1);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("rst_mvalid", {31'h0, m_valid}, 32'h0);
    chk("rst_sel", {28'h0, sel}, 32'h0);

    // zero-wait slave, then 3 wait states, then output stall at word 5
    wait_cfg = 0; run_frame(32'h1, -1, 16'd1);
    wait_cfg = 3; run_frame(32'h1, -1, 16'd2);
    wait_cfg = 0; run_frame(32'h1, 5, 16'd3);

    // slave hangs on the idx 7 write
    hang_en = 1'b1;
    log_n = 0;
    for (int i = 0; i < 8; i++) send_word(32'h50 + i);
    for (int t = 0; t < 400 && !err; t++) @(negedge clk);
    @(negedge clk);
    #1;
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_stb_cycles", last_stb_cycles, 255);
    chk("to_busy", {31'h0, busy}, 32'h0);
    chk("to_cyc", {31'h0, cyc}, 32'h0);
    chk("to_cnt", {16'h0, frame_cnt}, 32'd3);
    chk("to_log", log_n, 7);
    hang_en = 1'b0;
    for (int i = 8; i < 16; i++) send_word(32'h50 + i);
    repeat (5) @(negedge clk);
    chk("drop_busy", {31'h0, busy}, 32'h0);
    chk("drop_log", log_n, 7);
    chk("err_sticky", {31'h0, err}, 32'h1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_clr", {31'h0, err}, 32'h0);
    run_frame(32'h100, -1, 16'd4);

    // asynchronous reset while a read is outstanding
    wait_cfg = 3;
    log_n = 0;
    for (int i = 0; i < 16; i++) send_word(32'h200 + i);
    take_word(0, -1);
    for (int t = 0; t < 200 && !stb; t++) @(negedge clk);
    chk("pre_rst_stb", {31'h0, stb}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'h0, cyc}, 32'h0);
    chk("arst_stb", {31'h0, stb}, 32'h0);
    chk("arst_mvalid", {31'h0, m_valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_cnt", {16'h0, frame_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(32'h300, -1, 16'd1);

    // frame counter wrap
    wait_cfg = 0;
    @(negedge clk);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    run_frame(32'h400, -1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
